// File: rtl/format_input.sv
// -----------------------------------------------------------------------------
// format_input
//   Input-side companion of the seven-segment output formatter. Samples the
//   board slide switches and push buttons, runs each bit through a two-flop
//   synchronizer and an independent debouncer, detects key presses, and
//   holds them in sticky pending bits. Everything is packed into one 32-bit
//   word that the CPU reads as an I/O register.
//
// Ports:
//   clock  in   1   system clock, rising edge
//   resetn in   1   asynchronous active-low reset
//   sw     in  10   raw slide switches (1 = up), asynchronous
//   key    in   3   raw push buttons (0 = pressed), asynchronous
//   rd_en  in   1   CPU read strobe; clears pending bits one cycle later
//   indt   out 32   packed word: {8'h00, press_cnt, pending, key_lvl, sw}
//   irq    out  1   high while any pending bit is set
// -----------------------------------------------------------------------------
module format_input #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SW_WIDTH        = 10,
    parameter int KEY_WIDTH       = 3
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [SW_WIDTH-1:0]  sw,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 rd_en,
    output logic [31:0]          indt,
    output logic                 irq
);

    // Switches and keys are handled as one vector: keys in the upper bits.
    localparam int NB = SW_WIDTH + KEY_WIDTH;

    // Idle pin state: switches down, keys released (active-low, so 1).
    localparam logic [NB-1:0] IDLE_VAL = {{KEY_WIDTH{1'b1}}, {SW_WIDTH{1'b0}}};

    // Counter value at which a persistent difference is accepted.
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Number of simultaneous press events, zero-extended to the counter width.
    function automatic logic [7:0] count_ones(input logic [KEY_WIDTH-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < KEY_WIDTH; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    logic [NB-1:0]        raw_s;
    logic [NB-1:0]        sync1_r;
    logic [NB-1:0]        sync2_r;
    logic [NB-1:0]        stable_r;
    logic [15:0]          cnt_r [NB];
    logic [NB-1:0]        accept_s;
    logic [KEY_WIDTH-1:0] press_s;
    logic [KEY_WIDTH-1:0] pending_r;
    logic [KEY_WIDTH-1:0] pending_nxt_s;
    logic [7:0]           press_cnt_r;
    logic [KEY_WIDTH-1:0] key_lvl_s;

    assign raw_s = {key, sw};

    // Two-flop synchronizer for every raw pin.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_r <= IDLE_VAL;
            sync2_r <= IDLE_VAL;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Acceptance: the synchronized bit still differs from the stable value
    // on the cycle the counter has reached its last count.
    always_comb begin
        accept_s = '0;
        for (int i = 0; i < NB; i++) begin
            if ((sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST)) begin
                accept_s[i] = 1'b1;
            end else begin
                accept_s[i] = 1'b0;
            end
        end
    end

    // A press is an accepted key change whose stable value is still released
    // (1); an accepted change from pressed to released is a release and is
    // ignored. The press wins over a same-cycle read so it is never lost.
    always_comb begin
        press_s       = accept_s[NB-1:SW_WIDTH] & stable_r[NB-1:SW_WIDTH];
        pending_nxt_s = press_s | (pending_r & ~{KEY_WIDTH{rd_en}});
        key_lvl_s     = ~stable_r[NB-1:SW_WIDTH];
    end

    // Per-bit debounce counters and stable values. Any cycle where the
    // synchronized value matches the stable one restarts the count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stable_r <= IDLE_VAL;
            for (int i = 0; i < NB; i++) begin
                cnt_r[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= 16'd0;
                end else if (accept_s[i]) begin
                    stable_r[i] <= sync2_r[i];
                    cnt_r[i]    <= 16'd0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + 16'd1;
                end
            end
        end
    end

    // Sticky pending bits and the free-running press counter (wraps at 256).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pending_r   <= '0;
            press_cnt_r <= 8'd0;
        end else begin
            pending_r   <= pending_nxt_s;
            press_cnt_r <= press_cnt_r + count_ones(press_s);
        end
    end

    // Registered output word and interrupt, built from the current state so
    // a read during rd_en returns the pending bits that are being cleared.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            indt <= 32'd0;
            irq  <= 1'b0;
        end else begin
            indt <= {8'h00, press_cnt_r, pending_r, key_lvl_s, stable_r[SW_WIDTH-1:0]};
            irq  <= |pending_r;
        end
    end

endmodule

// File: tb/tb_format_input.sv
// -----------------------------------------------------------------------------
// tb_format_input
//   Self-checking bench for format_input with DEBOUNCE_CYCLES = 4. Expected
//   output words are pushed to a scoreboard queue when the stimulus is
//   applied and popped/compared once the debounce latency has elapsed.
// -----------------------------------------------------------------------------
module tb_format_input;

    logic        clock;
    logic        resetn;
    logic [9:0]  sw;
    logic [2:0]  key;
    logic        rd_en;
    logic [31:0] indt;
    logic        irq;

    int vectors;
    int miscompares;

    typedef struct {
        string       tag;
        logic [31:0] indt;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];

    format_input #(
        .DEBOUNCE_CYCLES(4),
        .SW_WIDTH(10),
        .KEY_WIDTH(3)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .sw    (sw),
        .key   (key),
        .rd_en (rd_en),
        .indt  (indt),
        .irq   (irq)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] e_indt, input logic e_irq);
        exp_t e;
        e.tag  = tag;
        e.indt = e_indt;
        e.irq  = e_irq;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, ".indt"}, indt, e.indt);
            check_val({e.tag, ".irq"}, {31'd0, irq}, {31'd0, e.irq});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        sw          = 10'h3FF;
        key         = 3'b111;
        rd_en       = 1'b0;

        // 1. Reset state, then the switch debounce after release.
        step(2);
        sb_push("reset", 32'h0000_0000, 1'b0);
        sb_check();
        resetn = 1'b1;
        sb_push("sw_not_yet", 32'h0000_0000, 1'b0);
        step(6);
        sb_check();
        sb_push("sw_debounced", 32'h0000_03FF, 1'b0);
        step(1);
        sb_check();

        // 2. Three-cycle glitch on key[0] is rejected.
        key = 3'b110;
        step(3);
        key = 3'b111;
        sb_push("glitch_rejected", 32'h0000_03FF, 1'b0);
        step(10);
        sb_check();

        // Held press: visible exactly 6 edges after the first low sample.
        key = 3'b110;
        sb_push("press0_not_yet", 32'h0000_03FF, 1'b0);
        step(6);
        sb_check();
        sb_push("press0", 32'h0001_27FF, 1'b1);
        step(1);
        sb_check();
        sb_push("press0_held", 32'h0001_27FF, 1'b1);
        step(4);
        sb_check();

        // 3. Read strobe: the read cycle still shows pending, next clears it.
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        sb_push("rd_value", 32'h0001_27FF, 1'b1);
        sb_check();
        sb_push("rd_cleared", 32'h0001_07FF, 1'b0);
        step(1);
        sb_check();

        // 4. Release (no event), re-press key[0], then key[1] press on a read.
        key = 3'b111;
        sb_push("release0", 32'h0001_03FF, 1'b0);
        step(8);
        sb_check();
        key = 3'b110;
        sb_push("repress0", 32'h0002_27FF, 1'b1);
        step(7);
        sb_check();
        key = 3'b100;
        step(5);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        sb_push("press1_rd_value", 32'h0002_27FF, 1'b1);
        sb_check();
        sb_push("press1_wins_rd", 32'h0003_4FFF, 1'b1);
        step(1);
        sb_check();

        // 5. Counter wrap with three simultaneous presses, starting from reset.
        key    = 3'b111;
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        sb_push("wrap_start", 32'h0000_03FF, 1'b0);
        step(7);
        sb_check();
        for (int i = 1; i <= 86; i++) begin
            key = 3'b000;
            step(7);
            if (i == 1) begin
                sb_push("triple_first", 32'h0003_FFFF, 1'b1);
                sb_check();
            end else if (i == 85) begin
                sb_push("triple_ff", 32'h00FF_FFFF, 1'b1);
                sb_check();
            end else if (i == 86) begin
                sb_push("triple_wrap", 32'h0002_FFFF, 1'b1);
                sb_check();
            end
            key = 3'b111;
            step(7);
        end
        sb_push("triple_released", 32'h0002_E3FF, 1'b1);
        sb_check();

        // 6. Async reset mid-debounce, then a full fresh debounce.
        key = 3'b110;
        step(4);
        resetn = 1'b0;
        #1;
        sb_push("async_reset", 32'h0000_0000, 1'b0);
        sb_check();
        step(2);
        resetn = 1'b1;
        sb_push("post_reset_not_yet", 32'h0000_0000, 1'b0);
        step(6);
        sb_check();
        sb_push("post_reset_press", 32'h0001_27FF, 1'b1);
        step(1);
        sb_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
